// File: rtl/conv_window_gen.sv
// K x K sliding-window generator: per-channel shift chain with row-spaced taps,
// raster position tracking and one-cycle window / frame-end pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_FILL | first KERNEL-1 rows arriving; no complete window exists yet
// ST_RUN  | window rows present; emit a window once x >= KERNEL-1
module conv_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 1,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int KERNEL     = 5
) (
  input  logic                                                   wg_clk,
  input  logic                                                   wg_rst_b,
  input  logic                                                   wg_clear,
  input  logic                                                   wg_valid_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]                      wg_data_i,
  output logic                                                   wg_valid_o,
  output logic [KERNEL-1:0][KERNEL-1:0][NUM_CH-1:0][DATA_WIDTH-1:0] wg_win_o,
  output logic [$clog2(IMG_HEIGHT)-1:0]                          wg_row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]                           wg_col_o,
  output logic                                                   wg_frame_done_o
);

  localparam int D  = (KERNEL - 1) * IMG_WIDTH + KERNEL;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(KERNEL - 1);
  localparam logic [YW-1:0] Y_OFF   = YW'(KERNEL - 1);
  localparam logic [YW-1:0] Y_RUN   = YW'(KERNEL - 2);

  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                               state_q, state_d;
  logic [D-1:0][NUM_CH-1:0][DATA_WIDTH-1:0] chain;
  logic [XW-1:0]                        x_q;
  logic [YW-1:0]                        y_q;
  logic                                 accept, x_last, y_last, fire, frame_end;

  // A clear in the same cycle drops the incoming pixel entirely.
  assign accept = wg_valid_i & ~wg_clear;
  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  always_ff @(posedge wg_clk or negedge wg_rst_b) begin
    if (!wg_rst_b) begin
      chain <= '0;
    end else if (accept) begin
      chain <= {chain[D-2:0], wg_data_i};
    end
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_col
      assign wg_win_o[r][c] = chain[(KERNEL-1-r)*IMG_WIDTH + (KERNEL-1-c)];
    end
  end

  always_ff @(posedge wg_clk or negedge wg_rst_b) begin
    if (!wg_rst_b) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fire      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept && x_last && (y_q == Y_RUN)) state_d = ST_RUN;
      end
      ST_RUN: begin
        fire = accept && (x_q >= X_FIRST);
        if (accept && x_last && y_last) begin
          frame_end = 1'b1;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (wg_clear) state_d = ST_FILL;
  end

  always_ff @(posedge wg_clk or negedge wg_rst_b) begin
    if (!wg_rst_b) begin
      x_q <= '0;
      y_q <= '0;
    end else if (wg_clear) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Pulses fall to 0 on any non-accepting cycle; position holds between windows.
  always_ff @(posedge wg_clk or negedge wg_rst_b) begin
    if (!wg_rst_b) begin
      wg_valid_o      <= 1'b0;
      wg_frame_done_o <= 1'b0;
      wg_row_o        <= '0;
      wg_col_o        <= '0;
    end else begin
      wg_valid_o      <= fire;
      wg_frame_done_o <= frame_end;
      if (fire) begin
        wg_row_o <= y_q - Y_OFF;
        wg_col_o <= x_q - X_FIRST;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised bench for conv_window_gen: a frame-image model predicts every
// window, position and pulse from the raster index of each accepted pixel.
module tb_conv_window_gen;
  localparam int DW = 8;
  localparam int NC = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int K  = 3;

  logic                          clk = 1'b0;
  logic                          rst_b;
  logic                          clear;
  logic                          valid_in;
  logic [NC-1:0][DW-1:0]         data;
  logic                          valid_out;
  logic [K-1:0][K-1:0][NC-1:0][DW-1:0] win;
  logic [$clog2(H)-1:0]          row;
  logic [$clog2(W)-1:0]          col;
  logic                          frame_done;

  conv_window_gen #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)
  ) dut (
    .wg_clk(clk), .wg_rst_b(rst_b), .wg_clear(clear), .wg_valid_i(valid_in),
    .wg_data_i(data), .wg_valid_o(valid_out), .wg_win_o(win), .wg_row_o(row),
    .wg_col_o(col), .wg_frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_n   = 0;
  int win_seen = 0;
  int img [W*H];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Channel c carries v + 64*c.
  function automatic logic [NC*DW-1:0] pix(input int v);
    return {8'(v + 128), 8'(v + 64), 8'(v)};
  endfunction

  task automatic step(input bit v, input bit clr, input int off);
    int y, x, pv, er, ec;
    bit ev, ed;
    valid_in = v;
    clear    = clr;
    pv       = off + acc_n;
    data     = v ? pix(pv) : NC*DW'($urandom);
    @(posedge clk);
    #1;
    ev = 0; ed = 0; er = 0; ec = 0;
    if (clr) begin
      acc_n = 0;
    end else if (v) begin
      y = acc_n / W;
      x = acc_n % W;
      img[acc_n] = pv;
      ev = (y >= K-1) && (x >= K-1);
      er = y - K + 1;
      ec = x - K + 1;
      ed = (acc_n == W*H - 1);
      acc_n = (acc_n + 1) % (W*H);
    end
    check("valid", valid_out, ev);
    check("frame_done", frame_done, ed);
    if (valid_out) win_seen++;
    if (ev) begin
      check("row", row, er);
      check("col", col, ec);
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          check($sformatf("win[%0d][%0d]", r, c), win[r][c], pix(img[(er+r)*W + ec + c]));
    end
    valid_in = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic run_pixels(input int count, input int off, input bit gaps);
    int done_cnt, iter;
    bit v;
    done_cnt = 0;
    iter = 0;
    while (done_cnt < count) begin
      v = gaps && iter < 200 ? 1'($urandom_range(0, 1)) : 1'b1;
      step(v, 1'b0, off);
      if (v) done_cnt++;
      iter++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_col"}, col, 0);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        check($sformatf("%s_win[%0d][%0d]", tag, r, c), win[r][c], 0);
  endtask

  initial begin
    rst_b    = 1'b0;
    clear    = 1'b0;
    valid_in = 1'b0;
    data     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_b = 1'b1;

    // Continuous single frame.
    win_seen = 0;
    run_pixels(W*H, 0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 0);
    check("win_count_cont", win_seen, 4);

    // Same frame with random gaps.
    win_seen = 0;
    run_pixels(W*H, 0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 0);
    check("win_count_gaps", win_seen, 4);

    // Two frames back-to-back, second offset by 100.
    win_seen = 0;
    run_pixels(W*H, 0, 1'b0);
    run_pixels(W*H, 100, 1'b0);
    check("win_count_b2b", win_seen, 8);

    // Clear with a coincident pixel after 9 accepts, then restart with new data.
    win_seen = 0;
    run_pixels(9, 0, 1'b0);
    step(1'b1, 1'b1, 0);
    check("clear_acc_idx", acc_n, 0);
    run_pixels(W*H, 50, 1'b1);
    check("win_count_clear", win_seen, 4);

    // Asynchronous reset mid-RUN.
    run_pixels(12, 0, 1'b0);
    #2 rst_b = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_held");
    #2 rst_b = 1'b1;
    acc_n = 0;
    win_seen = 0;
    run_pixels(W*H, 20, 1'b0);
    step(1'b0, 1'b0, 0);
    check("win_count_rst", win_seen, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Parametrised K×K sliding-window generator for the convolution layers. It accepts one multi-channel pixel per qualified cycle in raster order and keeps the last (KERNEL-1) image rows plus KERNEL pixels in an enable-gated shift chain per channel, with taps spaced IMG_WIDTH apart. It presents the full window once the window lies entirely inside the image, and tracks frame position and frame end. It sits between the input pixel stream and the MAC array.

## Interface
- DATA_WIDTH, 32: bits per channel sample
- NUM_CH, 1: channels carried in parallel per pixel
- IMG_WIDTH, 32: pixels per row; must be ≥ KERNEL
- IMG_HEIGHT, 32: rows per frame; must be ≥ KERNEL
- KERNEL, 5: window edge; must be ≥ 2
- wg_clk  in  1  clock, rising edge
- wg_rst_b  in  1  asynchronous reset, active low
- wg_clear  in  1  synchronous frame restart
- wg_valid_i  in  1  pixel qualifier; the chain shifts only when this is high
- wg_data_i  in  [NUM_CH-1:0][DATA_WIDTH-1:0]  input pixel
- wg_valid_o  out  1  window valid, one-cycle pulse per window
- wg_win_o  out  [KERNEL-1:0][KERNEL-1:0][NUM_CH-1:0][DATA_WIDTH-1:0]  window, indexed [r][c]
- wg_row_o  out  $clog2(IMG_HEIGHT)  window top-left row
- wg_col_o  out  $clog2(IMG_WIDTH)  window top-left column
- wg_frame_done_o  out  1  pulse: last pixel of the frame has been accepted

## Operation
- Chain depth is D = (KERNEL-1)*IMG_WIDTH + KERNEL flops per channel. Index 0 holds the newest accepted pixel.
- wg_win_o[r][c] is chain index (KERNEL-1-r)*IMG_WIDTH + (KERNEL-1-c). Relative to the newest accepted pixel (y,x), this is image pixel (y-K+1+r, x-K+1+c).
- wg_win_o is driven combinationally from the chain flops.
- Column counter x runs 0..IMG_WIDTH-1. On wrap it returns to 0 and row counter y increments. y runs 0..IMG_HEIGHT-1; after the last pixel both counters return to (0,0).
- Counters advance only on accepted pixels.
- State machine:
  - FILL: active while y < KERNEL-1. On accepting the last pixel of row KERNEL-2, move to RUN.
  - RUN: on accepting pixel (y,x) with x ≥ KERNEL-1, register wg_valid_o=1, wg_row_o=y-K+1, wg_col_o=x-K+1. On accepting the last pixel of the frame, pulse wg_frame_done_o and return to FILL.
- With KERNEL=2, FILL lasts exactly one row.
- Pixels with x < KERNEL-1 in RUN shift the chain but do not produce a window.
- wg_clear:
  - Returns counters to (0,0), state to FILL, and all output pulses to 0.
  - Has priority over a wg_valid_i in the same cycle; that pixel is dropped and does not shift.
  - Does not clear chain contents. Stale data is never exposed because wg_valid_o is gated.
- Multi-channel: all channels shift together under one enable. There is no cross-channel arithmetic.

## Timing
- Reset values:
  - All chain flops and wg_win_o: 0.
  - wg_valid_o, wg_frame_done_o, wg_row_o, wg_col_o: 0.
  - State: FILL.
- Latency: the pixel accepted on edge N produces wg_valid_o high in the cycle after edge N. wg_win_o is consistent with that pulse in the same cycle.
- wg_valid_o is high for exactly one cycle per window, even if wg_valid_i then stays low. Window and position hold their values until the next accept.
- wg_frame_done_o coincides with the wg_valid_o pulse for window (IMG_HEIGHT-K, IMG_WIDTH-K).
- Gaps in wg_valid_i are allowed and freeze everything except the output pulses, which drop to 0.
- Back-to-back frames need no idle cycle. The first window of frame 2 contains only frame-2 pixels, because its depth D is reached exactly at (K-1,K-1).
- Reset asserted mid-frame: all state clears immediately, without waiting for a clock edge. After release, the next accepted pixel is treated as (0,0).
- Throughput: one pixel per cycle. There is no backpressure, so the downstream block must always accept wg_valid_o.

## Test plan
All scenarios use DATA_WIDTH=8, NUM_CH=1, IMG 4×4, KERNEL=3, and pixel value 4y+x unless stated.
- Continuous stream, one frame:
  - The first wg_valid_o comes one cycle after pixel 10 is accepted, with window {0,1,2 / 4,5,6 / 8,9,10} and row/col (0,0).
  - Exactly 4 windows are produced, at positions (0,0),(0,1),(1,0),(1,1).
  - The last window is {5,6,7 / 9,10,11 / 13,14,15}, and wg_frame_done_o is high with it.
- Same stream with wg_valid_i toggling 1,0,0,1 randomly: the window contents and position sequence are identical to the continuous case, and no wg_valid_o appears during gaps.
- Two frames back-to-back, frame 2 with values +100: the first frame-2 window is {100,101,102 / 104,105,106 / 108,109,110}, produced 11 accepts into frame 2.
- wg_clear asserted together with wg_valid_i after 9 pixels:
  - The pixel is dropped and no window is produced.
  - The restarted frame's first window appears after its 11th accept, with correct values.
- wg_rst_b pulsed low mid-RUN: all outputs read 0 during reset, and afterwards the frame restarts as in the first scenario.
- NUM_CH=3, channels carrying v, v+64, v+128: each channel's window matches the single-channel result with that channel's offset.
